// File: rtl/vm_text_pkg.sv
// vm_text_pkg: screen geometry, writer FSM states and ASCII control codes
package vm_text_pkg;
    localparam int COLS       = 70;
    localparam int ROWS       = 30;
    localparam int PROMPT_LEN = 9;
    localparam int AW         = 12;
    typedef enum logic [2:0] {IDLE, PUT, SCROLL, CLRLINE, CLEAR} state_t;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_PR_LO = 8'h20;
    localparam logic [7:0] CH_PR_HI = 8'h7E;
endpackage

// File: rtl/vm_text_writer_if.sv
// vm_text_writer_if: byte input handshake plus video memory write/read port
interface vm_text_writer_if
    import vm_text_pkg::*;
#(
    parameter int AW = vm_text_pkg::AW
);
    logic          ch_valid;
    logic [7:0]    ch_data;
    logic          ch_ready;
    logic          clr_screen;
    logic          vm_we;
    logic [AW-1:0] vm_waddr;
    logic [7:0]    vm_wdata;
    logic [AW-1:0] vm_raddr;
    logic [7:0]    vm_rdata;
    modport master (
        output ch_valid, ch_data, clr_screen, vm_rdata,
        input  ch_ready, vm_we, vm_waddr, vm_wdata, vm_raddr
    );
    modport slave (
        input  ch_valid, ch_data, clr_screen, vm_rdata,
        output ch_ready, vm_we, vm_waddr, vm_wdata, vm_raddr
    );
endinterface

// File: rtl/vm_fill_counter.sv
// vm_fill_counter: linear sweep over len cells from base while enabled; done on the last cell
module vm_fill_counter
    import vm_text_pkg::*;
(
    input  logic          clk,
    input  logic          clrn,
    input  logic          en,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] len,
    output logic [AW-1:0] cnt,
    output logic [AW-1:0] addr,
    output logic          done
);
    assign addr = base + cnt;
    assign done = en && cnt == len - 1'b1;
    // returns to zero on done so every sweep starts from its base
    always_ff @(posedge clk or negedge clrn)
        if (!clrn) cnt <= '0;
        else if (en) cnt <= done ? '0 : cnt + 1'b1;
endmodule

// File: rtl/vm_text_writer.sv
// vm_text_writer: turns an ASCII byte stream into character cells with cursor, wrap, scroll and clear
module vm_text_writer
    import vm_text_pkg::*;
(
    input  logic            clk,
    input  logic            clrn,
    vm_text_writer_if.slave bus,
    output logic [4:0]      cur_row,
    output logic [6:0]      cur_col
);
    state_t        state;
    logic [6:0]    line_start;
    logic          scroll_pend;
    logic          fill_en, fill_done, accept, nl, is_print, last_col, last_row, scroll_rd;
    logic [AW-1:0] cnt, fill_addr, fill_base, fill_len, cur_addr;

    assign fill_en   = state inside {SCROLL, CLRLINE, CLEAR};
    assign fill_len  = state == SCROLL ? AW'(COLS * (ROWS - 1) + 1) :
                       state == CLRLINE ? AW'(COLS) : AW'(COLS * ROWS);
    assign fill_base = state == CLRLINE ? AW'(COLS * (ROWS - 1)) : '0;

    vm_fill_counter u_fill (
        .clk(clk), .clrn(clrn), .en(fill_en), .base(fill_base), .len(fill_len),
        .cnt(cnt), .addr(fill_addr), .done(fill_done)
    );

    // scroll reads one row ahead; the last sweep step only drains the pipeline
    assign scroll_rd     = state == SCROLL && cnt < AW'(COLS * (ROWS - 1));
    assign bus.vm_raddr  = scroll_rd ? cnt + AW'(COLS) : '0;
    assign bus.ch_ready  = state == IDLE;
    assign accept        = bus.ch_ready && bus.ch_valid && !bus.clr_screen;
    assign nl            = bus.ch_data == CH_CR || bus.ch_data == CH_LF;
    assign is_print      = bus.ch_data >= CH_PR_LO && bus.ch_data <= CH_PR_HI;
    assign last_col      = cur_col == 7'(COLS - 1);
    assign last_row      = cur_row == 5'(ROWS - 1);
    assign cur_addr      = AW'(cur_row) * AW'(COLS) + AW'(cur_col);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state        <= CLEAR;
            cur_row      <= '0;
            cur_col      <= 7'(PROMPT_LEN);
            line_start   <= 7'(PROMPT_LEN);
            scroll_pend  <= 1'b0;
            bus.vm_we    <= 1'b0;
            bus.vm_waddr <= '0;
            bus.vm_wdata <= '0;
        end else begin
            bus.vm_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.clr_screen) state <= CLEAR;
                    else if (accept && nl) begin
                        cur_col    <= 7'(PROMPT_LEN);
                        line_start <= 7'(PROMPT_LEN);
                        if (last_row) state <= SCROLL;
                        else cur_row <= cur_row + 5'd1;
                    end else if (accept && bus.ch_data == CH_BS && cur_col != line_start) begin
                        cur_col      <= cur_col - 7'd1;
                        bus.vm_we    <= 1'b1;
                        bus.vm_waddr <= cur_addr - 1'b1;
                        bus.vm_wdata <= CH_SPACE;
                        state        <= PUT;
                    end else if (accept && is_print) begin
                        bus.vm_we    <= 1'b1;
                        bus.vm_waddr <= cur_addr;
                        bus.vm_wdata <= bus.ch_data;
                        state        <= PUT;
                        cur_col      <= last_col ? 7'd0 : cur_col + 7'd1;
                        if (last_col) begin
                            line_start <= 7'd0;
                            if (last_row) scroll_pend <= 1'b1;
                            else cur_row <= cur_row + 5'd1;
                        end
                    end
                end
                PUT: begin
                    state       <= scroll_pend ? SCROLL : IDLE;
                    scroll_pend <= 1'b0;
                end
                SCROLL: begin
                    if (cnt != '0) begin
                        bus.vm_we    <= 1'b1;
                        bus.vm_waddr <= cnt - 1'b1;
                        bus.vm_wdata <= bus.vm_rdata;
                    end
                    if (fill_done) state <= CLRLINE;
                end
                CLRLINE, CLEAR: begin
                    bus.vm_we    <= 1'b1;
                    bus.vm_waddr <= fill_addr;
                    bus.vm_wdata <= CH_SPACE;
                    if (fill_done) begin
                        state <= IDLE;
                        if (state == CLEAR) begin
                            cur_row    <= '0;
                            cur_col    <= 7'(PROMPT_LEN);
                            line_start <= 7'(PROMPT_LEN);
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_vm_text_writer.sv
// tb_vm_text_writer: directed + random byte stream against a 2-D screen model with a behavioural RAM
module tb_vm_text_writer;
    import vm_text_pkg::*;

    logic clk = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    vm_text_writer_if #(.AW(AW)) bus ();
    logic [4:0] cur_row;
    logic [6:0] cur_col;

    vm_text_writer dut (.clk(clk), .clrn(clrn), .bus(bus), .cur_row(cur_row), .cur_col(cur_col));

    logic [7:0]  mem [COLS*ROWS];
    logic [7:0]  scr [ROWS][COLS];
    logic [19:0] wq[$];
    logic [19:0] exp_q[$];
    int rr, rc, rls, oob = 0;
    int total = 0, bad = 0;

    // synchronous-read video RAM, logging every write the DUT issues
    always @(posedge clk) begin
        if (bus.vm_we) begin
            if (bus.vm_waddr < AW'(COLS*ROWS)) mem[bus.vm_waddr] <= bus.vm_wdata;
            else oob++;
            wq.push_back({bus.vm_waddr, bus.vm_wdata});
        end
        if (bus.vm_raddr >= AW'(COLS*ROWS)) oob++;
        bus.vm_rdata <= bus.vm_raddr < AW'(COLS*ROWS) ? mem[bus.vm_raddr] : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic ref_home();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = 8'h20;
        rr = 0; rc = PROMPT_LEN; rls = PROMPT_LEN;
    endtask

    task automatic ref_scroll();
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
        for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h20;
    endtask

    task automatic model_step(input logic [7:0] b);
        if (b == 8'h0D || b == 8'h0A) begin
            if (rr < ROWS - 1) rr++;
            else ref_scroll();
            rc = PROMPT_LEN; rls = PROMPT_LEN;
        end else if (b == 8'h08) begin
            if (rc != rls) begin
                rc--;
                scr[rr][rc] = 8'h20;
            end
        end else if (b >= 8'h20 && b <= 8'h7E) begin
            scr[rr][rc] = b;
            if (rc + 1 == COLS) begin
                rc = 0; rls = 0;
                if (rr == ROWS - 1) ref_scroll();
                else rr++;
            end else rc++;
        end
    endtask

    function automatic int screen_bad();
        int n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (mem[r*COLS+c] !== scr[r][c]) n++;
        return n;
    endfunction

    function automatic int clear_errs();
        int n = 0;
        for (int i = 0; i < wq.size(); i++)
            if (wq[i] !== {12'(i), 8'h20}) n++;
        return n;
    endfunction

    task automatic wait_ready(output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            if (bus.ch_ready) break;
            cyc++;
            if (cyc > 6000) begin
                chk("ready_timeout", 32'(bus.ch_ready), 1);
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input bit clr_busy, output int cyc);
        bus.ch_data  = b;
        bus.ch_valid = 1'b1;
        @(negedge clk);
        bus.ch_valid = 1'b0;
        if (clr_busy) begin
            bus.clr_screen = 1'b1;
            @(negedge clk);
            bus.clr_screen = 1'b0;
        end
        wait_ready(cyc);
        cyc += int'(clr_busy);
        model_step(b);
    endtask

    task automatic put(input logic [7:0] b);
        int cyc;
        send(b, 1'b0, cyc);
    endtask

    task automatic chk_cursor(input string tag);
        chk({tag, "_row"}, 32'(cur_row), rr);
        chk({tag, "_col"}, 32'(cur_col), rc);
    endtask

    initial begin
        int cyc, r, errs;
        logic [7:0] b;
        for (int i = 0; i < COLS*ROWS; i++) mem[i] = 8'hEE;
        bus.ch_valid = 1'b0; bus.ch_data = 8'h00; bus.clr_screen = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.ch_ready), 0);
        chk("rst_we", 32'(bus.vm_we), 0);
        chk("rst_waddr", 32'(bus.vm_waddr), 0);
        chk("rst_row", 32'(cur_row), 0);
        chk("rst_col", 32'(cur_col), 9);

        wq.delete();
        clrn = 1'b1;
        wait_ready(cyc);
        ref_home();
        chk("clear_writes", wq.size(), 2100);
        chk("clear_seq", clear_errs(), 0);
        chk("clear_ready", 32'(bus.ch_ready), 1);
        chk_cursor("clear");
        chk("clear_screen", screen_bad(), 0);

        wq.delete();
        put(8'h41); put(8'h42);
        chk("ab_writes", wq.size(), 2);
        chk("a_write", wq[0], {12'd9, 8'h41});
        chk("b_write", wq[1], {12'd10, 8'h42});
        chk_cursor("ab");

        wq.delete();
        put(8'h08); put(8'h08);
        chk("bs_writes", wq.size(), 2);
        chk("bs1_write", wq[0], {12'd10, 8'h20});
        chk("bs2_write", wq[1], {12'd9, 8'h20});
        wq.delete();
        put(8'h08);
        chk("bs_noop_writes", wq.size(), 0);
        chk_cursor("bs");

        wq.delete();
        for (int i = 0; i < 61; i++) put(8'(32 + $urandom_range(0, 94)));
        chk("line_writes", wq.size(), 61);
        chk("line_last_addr", 32'(wq[60][19:8]), 69);
        chk_cursor("wrap");
        wq.delete();
        put(8'h08);
        chk("wrap_bs_writes", wq.size(), 0);
        chk_cursor("wrap_bs");

        for (int i = 0; i < 28; i++) put(($urandom_range(0, 1) != 0) ? 8'h0A : 8'h0D);
        for (int i = 0; i < 11; i++) put(8'(32 + $urandom_range(0, 94)));
        chk_cursor("pre_scroll");
        chk("pre_scroll_screen", screen_bad(), 0);

        exp_q.delete();
        for (int i = 0; i < COLS*(ROWS-1); i++)
            exp_q.push_back({12'(i), scr[(i+COLS)/COLS][(i+COLS)%COLS]});
        for (int i = 0; i < COLS; i++) exp_q.push_back({12'(COLS*(ROWS-1)+i), 8'h20});
        wq.delete();
        send(8'h0A, 1'b1, cyc);
        chk("scroll_busy", cyc, 2100);
        chk("scroll_writes", wq.size(), 2100);
        errs = 0;
        for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
            if (wq[i] !== exp_q[i]) errs++;
        chk("scroll_seq", errs, 0);
        chk_cursor("scroll");
        chk("scroll_screen", screen_bad(), 0);

        wq.delete();
        bus.ch_data = 8'h41; bus.ch_valid = 1'b1; bus.clr_screen = 1'b1;
        @(negedge clk);
        bus.ch_valid = 1'b0; bus.clr_screen = 1'b0;
        wait_ready(cyc);
        ref_home();
        chk("clr_writes", wq.size(), 2100);
        chk("clr_seq", clear_errs(), 0);
        chk_cursor("clr");
        chk("clr_screen", screen_bad(), 0);

        put(8'h5A);
        bus.clr_screen = 1'b1;
        @(negedge clk);
        bus.clr_screen = 1'b0;
        repeat (50) @(negedge clk);
        clrn = 1'b0;
        #1;
        chk("midrst_ready", 32'(bus.ch_ready), 0);
        chk("midrst_we", 32'(bus.vm_we), 0);
        chk("midrst_waddr", 32'(bus.vm_waddr), 0);
        chk("midrst_raddr", 32'(bus.vm_raddr), 0);
        chk("midrst_col", 32'(cur_col), 9);
        @(negedge clk);
        wq.delete();
        clrn = 1'b1;
        wait_ready(cyc);
        ref_home();
        chk("midrst_writes", wq.size(), 2100);
        chk("midrst_seq", clear_errs(), 0);
        chk_cursor("midrst");

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            b = r < 4 ? 8'h0A : r < 7 ? 8'h0D : r < 13 ? 8'h08 :
                r < 17 ? 8'($urandom_range(127, 255)) : 8'($urandom_range(32, 126));
            put(b);
            chk_cursor("rnd");
            chk("rnd_screen", screen_bad(), 0);
        end
        chk("addr_range", oob, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
